regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised, multi-port successor to the lab datapath register file. It holds NREGS registers of DATA_W bits and provides one write port and two independent combinational read ports (A and B) that feed the datapath's A and B operand loads. Additions over the single-port file:
- synchronous reset to zero;
- optional same-cycle write-to-read bypass;
- per-register "written since reset" valid bits;
- per-register busy (pending-write) scoreboard that the controller FSM sets at issue time.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- NREGS, 8, number of registers (2..64; need not be a power of two)
- ADDR_W, $clog2(NREGS), index width (derived; do not override)
- BYPASS, 1, 1 = read port returns data_in when a write to the same index is occurring this cycle; 0 = read returns stored value

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- write  in  1  write enable
- writenum  in  ADDR_W  write index
- data_in  in  DATA_W  write data
- reserve  in  1  mark register reservenum busy
- reservenum  in  ADDR_W  reserve index
- readnum_a, readnum_b  in  ADDR_W  read indices
- data_out_a, data_out_b  out  DATA_W  read data
- valid_a, valid_b  out  1  indexed register written since last reset
- busy_a, busy_b  out  1  indexed register has a pending reservation
- busy_any  out  1  OR of all busy bits

## Operation
Reset:
- all registers become 0, all valid bits 0, all busy bits 0.
- Reset takes priority over write and reserve in the same cycle.

Write (write=1 at the clock edge, index in range):
- R[writenum] <= data_in
- valid[writenum] <= 1
- busy[writenum] <= 0

Reserve (reserve=1 at the clock edge, index in range):
- busy[reservenum] <= 1.
- If a write and a reserve hit the same index in the same cycle, the register takes data_in, valid=1, busy ends at 1 (the new reservation wins).

Read ports:
- Purely combinational from readnum_x; both ports may address the same register.
- BYPASS=1 and write=1 and writenum==readnum_x (in range):
  - data_out_x = data_in
  - valid_x = 1
  - busy_x = the stored busy bit (not bypassed)
- BYPASS=0: outputs reflect state only; a write is visible the cycle after the edge.

Out-of-range index (>= NREGS):
- Write and reserve are ignored.
- Reads return data 0, valid 0, busy 0.

Otherwise, register contents, valid bits and busy bits hold.

## Timing
- Write latency: one edge. The stored value is visible on data_out at the first delta after the edge (BYPASS=0), or in the same cycle as the write (BYPASS=1).
- Read latency: zero cycles (combinational). No clock is needed to change readnum.
- Busy set and clear take effect at the edge; busy_x and busy_any update in the following cycle.
- Reset asserted mid-sequence (a reservation outstanding, write in flight) clears everything at that edge. The in-flight write is lost.
- Output values while reset=1 before the first edge are undefined. From the first reset edge onward, all outputs follow the rules above.
- No combinational path from reserve or reservenum to any output.

## Structure
- Package regfile_pkg:
  - localparams REGFILE_DATA_W_DEF=16 and REGFILE_NREGS_DEF=8
  - a function returning the index-in-range check, shared by the write, reserve and read decode
- One sub-module, vDFFE_r: a parametrised-width enabled D flip-flop with synchronous reset to 0. Instantiated NREGS times for data.
- Valid and busy bit vectors are plain NREGS-bit registers in the top level.
- Write and reserve decoders are one-hot, NREGS wide.
- Read ports are two instances of the same mux logic (generate or function).

## Test plan
1. Reset, then write 42 to R3 with write=1. Next cycle readnum_a=3, readnum_b=3 -> both data_out=42, valid=1, busy=0. readnum_a=6 -> data_out_a=0, valid_a=0 (not x).
2. write=0, data_in=91, writenum=3 -> R3 stays 42. With BYPASS=1 and write=1, data_in=91, writenum=3, readnum_a=3 in the same cycle -> data_out_a=91 before the edge. With BYPASS=0 -> 42 before the edge, 91 after.
3. reserve=1, reservenum=5 -> busy_b=1 (readnum_b=5) and busy_any=1 the next cycle. Write 7 to R5 -> busy clears, data 7, busy_any=0. Same-cycle reserve and write to R5 with 9 -> data 9, valid 1, busy 1.
4. Reset asserted in the same cycle as a write of 0xFFFF to R0 and a reserve of R2 -> all data 0, all valid 0, busy_any=0 after the edge.
5. NREGS=6 build: write 0x1234 to index 7 and reserve index 6 -> no register changes, busy_any=0. Reads of indices 6 and 7 -> 0, valid 0, busy 0.
6. DATA_W=32, NREGS=16: write 0xDEADBEEF to R15 and 0x1 to R0 on consecutive cycles -> simultaneous reads A=15, B=0 return both values correctly.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the multi-port register file.
//   REGFILE_DATA_W_DEF : default register width in bits
//   REGFILE_NREGS_DEF  : default number of registers
//   idx_in_range()     : index check used by the write, reserve and read decode.
//                        NREGS need not be a power of two, so some encodable
//                        indices do not name a register.
package regfile_pkg;

    localparam int REGFILE_DATA_W_DEF = 32'd16;
    localparam int REGFILE_NREGS_DEF  = 32'd8;

    // True when idx names an existing register
    function automatic logic idx_in_range(input int unsigned idx, input int unsigned nregs);
        return (idx < nregs);
    endfunction

endpackage

// File: rtl/vDFFE_r.sv
// vDFFE_r
// Enabled D flip-flop of parametrised width. It has a synchronous reset to zero,
// and reset takes priority over the enable.
//   clk   : clock, rising edge
//   reset : synchronous active-high clear
//   en    : load enable
//   d     : next value
//   q     : stored value
module vDFFE_r #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage element: clear on reset, otherwise load when enabled
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= {WIDTH{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Register file with NREGS registers of DATA_W bits. It has one write port, two
// combinational read ports, per-register valid bits ("written since reset") and
// a per-register busy scoreboard that the controller sets at issue time.
//   clk, reset            : clock and synchronous active-high reset
//   write/writenum/data_in: write port
//   reserve/reservenum    : marks a register busy (pending write)
//   readnum_a/readnum_b   : read indices
//   data_out_x            : read data (data_in when bypassing a same-index write)
//   valid_x               : indexed register written since reset
//   busy_x                : indexed register has an outstanding reservation
//   busy_any              : at least one register is busy
// Indices >= NREGS are ignored by write and reserve. Reads of such indices
// return zero for data, valid and busy.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W_DEF,
    parameter int NREGS  = REGFILE_NREGS_DEF,
    parameter int ADDR_W = $clog2(NREGS),
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] reservenum,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    output logic              valid_a,
    output logic              valid_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              busy_any
);

    logic                          wr_en_s;
    logic                          rsv_en_s;
    logic [NREGS-1:0]              wr_onehot_s;
    logic [NREGS-1:0]              rsv_onehot_s;
    logic [NREGS-1:0][DATA_W-1:0]  reg_q_s;
    logic [NREGS-1:0]              valid_r;
    logic [NREGS-1:0]              busy_r;
    logic [NREGS-1:0]              valid_nxt_s;
    logic [NREGS-1:0]              busy_nxt_s;
    logic                          busy_any_r;
    logic [DATA_W+1:0]             rd_a_s;
    logic [DATA_W+1:0]             rd_b_s;

    // One read port: stored state for in-range indices, with an optional bypass of
    // a same-cycle write. The bypass covers data and valid only. Busy always
    // reflects the stored scoreboard. Result packing is {data, valid, busy}.
    function automatic logic [DATA_W+1:0] read_port(
        input logic [ADDR_W-1:0]             idx,
        input logic [NREGS-1:0][DATA_W-1:0]  regs,
        input logic [NREGS-1:0]              valid_vec,
        input logic [NREGS-1:0]              busy_vec,
        input logic                          wr_en,
        input logic [ADDR_W-1:0]             wr_idx,
        input logic [DATA_W-1:0]             wr_data
    );
        logic [DATA_W-1:0] data_v;
        logic              valid_v;
        logic              busy_v;
        logic              hit_v;
        if (idx_in_range(32'(idx), NREGS)) begin
            data_v  = regs[idx];
            valid_v = valid_vec[idx];
            busy_v  = busy_vec[idx];
        end else begin
            data_v  = {DATA_W{1'b0}};
            valid_v = 1'b0;
            busy_v  = 1'b0;
        end
        // wr_en already includes the range check, so an equal index is a real register
        hit_v = BYPASS & wr_en & (wr_idx == idx);
        return {(hit_v ? wr_data : data_v), (hit_v | valid_v), busy_v};
    endfunction

    // One-hot write and reserve decoders; out-of-range indices decode to all zeros
    always_comb begin
        wr_en_s      = write   & idx_in_range(32'(writenum),   NREGS);
        rsv_en_s     = reserve & idx_in_range(32'(reservenum), NREGS);
        wr_onehot_s  = {NREGS{1'b0}};
        rsv_onehot_s = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            wr_onehot_s[i]  = wr_en_s  & (writenum   == ADDR_W'(i));
            rsv_onehot_s[i] = rsv_en_s & (reservenum == ADDR_W'(i));
        end
    end

    // Next valid/busy vectors. A write clears busy, but a same-cycle reservation of
    // the same register wins, because it belongs to a newer instruction.
    always_comb begin
        valid_nxt_s = valid_r | wr_onehot_s;
        busy_nxt_s  = (busy_r & ~wr_onehot_s) | rsv_onehot_s;
    end

    // Valid and busy scoreboards. busy_any is registered from the next-state busy
    // vector, so it lines up with busy_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r    <= {NREGS{1'b0}};
            busy_r     <= {NREGS{1'b0}};
            busy_any_r <= 1'b0;
        end else begin
            valid_r    <= valid_nxt_s;
            busy_r     <= busy_nxt_s;
            busy_any_r <= |busy_nxt_s;
        end
    end

    // Data storage: one enabled flop per register, loaded from its write-decoder bit
    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        vDFFE_r #(
            .WIDTH (DATA_W)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (wr_onehot_s[g]),
            .d     (data_in),
            .q     (reg_q_s[g])
        );
    end

    // Two identical read ports
    always_comb begin
        rd_a_s = read_port(readnum_a, reg_q_s, valid_r, busy_r, wr_en_s, writenum, data_in);
        rd_b_s = read_port(readnum_b, reg_q_s, valid_r, busy_r, wr_en_s, writenum, data_in);
    end

    assign data_out_a = rd_a_s[DATA_W+1:2];
    assign valid_a    = rd_a_s[1];
    assign busy_a     = rd_a_s[0];
    assign data_out_b = rd_b_s[DATA_W+1:2];
    assign valid_b    = rd_b_s[1];
    assign busy_b     = rd_b_s[0];
    assign busy_any   = busy_any_r;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Drives three builds of regfile_mp from one stimulus bus:
//   dut0: DATA_W=16, NREGS=8,  BYPASS=1
//   dut1: DATA_W=16, NREGS=6,  BYPASS=0
//   dut2: DATA_W=32, NREGS=16, BYPASS=1
// Each build is compared every cycle against an array model of the register
// file. Directed steps add literal expectations on top of that.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset, write, reserve;
    logic [3:0]  writenum, reservenum, ra, rb;
    logic [31:0] data_in;

    int checks   = 0;
    int failures = 0;
    bit seen_reset = 1'b0;

    wire [15:0] d0_a, d0_b, d1_a, d1_b;
    wire [31:0] d2_a, d2_b;
    wire d0_va, d0_vb, d0_ba, d0_bb, d0_any;
    wire d1_va, d1_vb, d1_ba, d1_bb, d1_any;
    wire d2_va, d2_vb, d2_ba, d2_bb, d2_any;

    regfile_mp #(.DATA_W(16), .NREGS(8), .BYPASS(1'b1)) dut0 (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum[2:0]),
        .data_in(data_in[15:0]), .reserve(reserve), .reservenum(reservenum[2:0]),
        .readnum_a(ra[2:0]), .readnum_b(rb[2:0]), .data_out_a(d0_a), .data_out_b(d0_b),
        .valid_a(d0_va), .valid_b(d0_vb), .busy_a(d0_ba), .busy_b(d0_bb), .busy_any(d0_any));

    regfile_mp #(.DATA_W(16), .NREGS(6), .BYPASS(1'b0)) dut1 (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum[2:0]),
        .data_in(data_in[15:0]), .reserve(reserve), .reservenum(reservenum[2:0]),
        .readnum_a(ra[2:0]), .readnum_b(rb[2:0]), .data_out_a(d1_a), .data_out_b(d1_b),
        .valid_a(d1_va), .valid_b(d1_vb), .busy_a(d1_ba), .busy_b(d1_bb), .busy_any(d1_any));

    regfile_mp #(.DATA_W(32), .NREGS(16), .BYPASS(1'b1)) dut2 (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum),
        .data_in(data_in), .reserve(reserve), .reservenum(reservenum),
        .readnum_a(ra), .readnum_b(rb), .data_out_a(d2_a), .data_out_b(d2_b),
        .valid_a(d2_va), .valid_b(d2_vb), .busy_a(d2_ba), .busy_b(d2_bb), .busy_any(d2_any));

    always #5 clk = ~clk;

    // Model configuration per build
    int          NR  [3] = '{8, 6, 16};
    int          AW  [3] = '{3, 3, 4};
    logic [31:0] DM  [3] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};
    bit          BYP [3] = '{1'b1, 1'b0, 1'b1};

    // Model state
    logic [31:0] m_data  [3][16];
    bit          m_valid [3][16];
    bit          m_busy  [3][16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {data, valid, busy} for a read of idx on build k
    function automatic logic [33:0] exp_rd(input int k, input logic [3:0] idx);
        int          am, i, w;
        logic [31:0] d;
        logic        v, b;
        am = (1 << AW[k]) - 1;
        i  = int'(idx) & am;
        w  = int'(writenum) & am;
        if (i >= NR[k]) return 34'd0;
        d = m_data[k][i];
        v = m_valid[k][i];
        b = m_busy[k][i];
        if (BYP[k] && write && (w == i)) begin
            d = data_in & DM[k];
            v = 1'b1;
        end
        return {d, v, b};
    endfunction

    // Model update at each rising edge
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int am, w, r;
            am = (1 << AW[k]) - 1;
            w  = int'(writenum) & am;
            r  = int'(reservenum) & am;
            if (reset) begin
                for (int i = 0; i < 16; i++) begin
                    m_data[k][i]  = 32'd0;
                    m_valid[k][i] = 1'b0;
                    m_busy[k][i]  = 1'b0;
                end
            end else begin
                if (write && w < NR[k]) begin
                    m_data[k][w]  = data_in & DM[k];
                    m_valid[k][w] = 1'b1;
                    m_busy[k][w]  = 1'b0;
                end
                if (reserve && r < NR[k]) m_busy[k][r] = 1'b1;
            end
        end
        if (reset) seen_reset = 1'b1;
    end

    task automatic cmp(input int k, input logic [31:0] da, input logic va, input logic ba,
                       input logic [31:0] db, input logic vb, input logic bb, input logic bany);
        logic [33:0] ea, eb;
        logic        eany;
        ea = exp_rd(k, ra);
        eb = exp_rd(k, rb);
        eany = 1'b0;
        for (int i = 0; i < NR[k]; i++) eany = eany | m_busy[k][i];
        chk($sformatf("m%0d_data_a", k), da, ea[33:2]);
        chk($sformatf("m%0d_valid_a", k), {31'd0, va}, {31'd0, ea[1]});
        chk($sformatf("m%0d_busy_a", k), {31'd0, ba}, {31'd0, ea[0]});
        chk($sformatf("m%0d_data_b", k), db, eb[33:2]);
        chk($sformatf("m%0d_valid_b", k), {31'd0, vb}, {31'd0, eb[1]});
        chk($sformatf("m%0d_busy_b", k), {31'd0, bb}, {31'd0, eb[0]});
        chk($sformatf("m%0d_busy_any", k), {31'd0, bany}, {31'd0, eany});
    endtask

    // Compare process: every falling edge once reset has been applied
    always @(negedge clk) begin
        if (seen_reset) begin
            cmp(0, {16'd0, d0_a}, d0_va, d0_ba, {16'd0, d0_b}, d0_vb, d0_bb, d0_any);
            cmp(1, {16'd0, d1_a}, d1_va, d1_ba, {16'd0, d1_b}, d1_vb, d1_bb, d1_any);
            cmp(2, d2_a, d2_va, d2_ba, d2_b, d2_vb, d2_bb, d2_any);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        reset   = 1'b0;
        write   = 1'b0;
        reserve = 1'b0;
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; reserve = 1'b0;
        writenum = 4'd0; reservenum = 4'd0; data_in = 32'd0; ra = 4'd0; rb = 4'd0;
        step();
        mid();
        chk("rst_d0_data_a", {16'd0, d0_a}, 32'd0);
        chk("rst_d0_valid_a", {31'd0, d0_va}, 32'd0);
        chk("rst_d2_busy_any", {31'd0, d2_any}, 32'd0);

        // Write 42 to R3, then read it on both ports
        idle(); write = 1'b1; writenum = 4'd3; data_in = 32'd42;
        step();
        idle(); ra = 4'd3; rb = 4'd3;
        mid();
        chk("t1_d0_data_a", {16'd0, d0_a}, 32'd42);
        chk("t1_d0_data_b", {16'd0, d0_b}, 32'd42);
        chk("t1_d0_valid_a", {31'd0, d0_va}, 32'd1);
        chk("t1_d0_busy_a", {31'd0, d0_ba}, 32'd0);
        chk("t1_d2_data_a", d2_a, 32'd42);
        ra = 4'd6; #1;
        chk("t1_d0_data_a6", {16'd0, d0_a}, 32'd0);
        chk("t1_d0_valid_a6", {31'd0, d0_va}, 32'd0);
        chk("t1_d1_data_a6", {16'd0, d1_a}, 32'd0);

        // No write keeps 42; write of 91 bypasses only on BYPASS builds
        step();
        data_in = 32'd91; writenum = 4'd3; ra = 4'd3;
        mid();
        chk("t2_hold_d0", {16'd0, d0_a}, 32'd42);
        write = 1'b1; #1;
        chk("t2_bypass_d0", {16'd0, d0_a}, 32'd91);
        chk("t2_nobypass_d1", {16'd0, d1_a}, 32'd42);
        step();
        idle();
        mid();
        chk("t2_after_d1", {16'd0, d1_a}, 32'd91);
        chk("t2_after_d0", {16'd0, d0_a}, 32'd91);

        // Reserve R5: busy appears only after the edge
        step();
        reserve = 1'b1; reservenum = 4'd5; rb = 4'd5;
        mid();
        chk("t3_busy_pre_d0", {31'd0, d0_bb}, 32'd0);
        chk("t3_any_pre_d0", {31'd0, d0_any}, 32'd0);
        step();
        idle();
        mid();
        chk("t3_busy_d0", {31'd0, d0_bb}, 32'd1);
        chk("t3_any_d0", {31'd0, d0_any}, 32'd1);
        chk("t3_busy_d1", {31'd0, d1_bb}, 32'd1);
        write = 1'b1; writenum = 4'd5; data_in = 32'd7;
        step();
        idle();
        mid();
        chk("t3_wr_data_d0", {16'd0, d0_b}, 32'd7);
        chk("t3_wr_busy_d0", {31'd0, d0_bb}, 32'd0);
        chk("t3_wr_any_d0", {31'd0, d0_any}, 32'd0);
        write = 1'b1; reserve = 1'b1; writenum = 4'd5; reservenum = 4'd5; data_in = 32'd9;
        step();
        idle();
        mid();
        chk("t3_both_data_d0", {16'd0, d0_b}, 32'd9);
        chk("t3_both_valid_d0", {31'd0, d0_vb}, 32'd1);
        chk("t3_both_busy_d0", {31'd0, d0_bb}, 32'd1);

        // Reset wins over a same-cycle write and reserve
        reset = 1'b1; write = 1'b1; writenum = 4'd0; data_in = 32'h0000_FFFF;
        reserve = 1'b1; reservenum = 4'd2;
        step();
        idle(); ra = 4'd0; rb = 4'd5;
        mid();
        chk("t4_data_a_d0", {16'd0, d0_a}, 32'd0);
        chk("t4_valid_a_d0", {31'd0, d0_va}, 32'd0);
        chk("t4_data_b_d0", {16'd0, d0_b}, 32'd0);
        chk("t4_any_d0", {31'd0, d0_any}, 32'd0);
        chk("t4_any_d2", {31'd0, d2_any}, 32'd0);

        // Out-of-range write/reserve on the NREGS=6 build
        write = 1'b1; writenum = 4'd7; data_in = 32'h0000_1234;
        reserve = 1'b1; reservenum = 4'd6;
        step();
        idle(); ra = 4'd6; rb = 4'd7;
        mid();
        chk("t5_d1_data_a", {16'd0, d1_a}, 32'd0);
        chk("t5_d1_valid_a", {31'd0, d1_va}, 32'd0);
        chk("t5_d1_busy_a", {31'd0, d1_ba}, 32'd0);
        chk("t5_d1_data_b", {16'd0, d1_b}, 32'd0);
        chk("t5_d1_valid_b", {31'd0, d1_vb}, 32'd0);
        chk("t5_d1_any", {31'd0, d1_any}, 32'd0);
        chk("t5_d0_data_b", {16'd0, d0_b}, 32'h0000_1234);
        chk("t5_d0_any", {31'd0, d0_any}, 32'd1);

        // 32-bit build: R15 and R0 read back together
        step();
        write = 1'b1; writenum = 4'd15; data_in = 32'hDEAD_BEEF;
        step();
        writenum = 4'd0; data_in = 32'h0000_0001;
        step();
        idle(); ra = 4'd15; rb = 4'd0;
        mid();
        chk("t6_d2_data_a", d2_a, 32'hDEAD_BEEF);
        chk("t6_d2_data_b", d2_b, 32'h0000_0001);
        chk("t6_d2_valid_a", {31'd0, d2_va}, 32'd1);
        chk("t6_d2_valid_b", {31'd0, d2_vb}, 32'd1);

        // Random traffic, checked by the model on every cycle
        for (int n = 0; n < 400; n++) begin
            step();
            reset      = ($urandom_range(0, 39) == 0);
            write      = ($urandom_range(0, 1) == 1);
            reserve    = ($urandom_range(0, 2) == 0);
            writenum   = 4'($urandom_range(0, 15));
            reservenum = ($urandom_range(0, 3) == 0) ? writenum : 4'($urandom_range(0, 15));
            data_in    = $urandom;
            ra         = ($urandom_range(0, 2) == 0) ? writenum : 4'($urandom_range(0, 15));
            rb         = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
        end
        step();
        idle();
        mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
